// File: rtl/process_allocator_arbiter_pkg.sv
// Shared definitions for the process-allocator arbiter: FSM encoding,
// program-counter width and the "no PID available" sentinel.
package process_allocator_arbiter_pkg;

  localparam int unsigned PC_BITS  = 9;
  localparam int unsigned PID_NONE = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    RESP  = 2'd2,
    DRAIN = 2'd3
  } arbState_t;

  // Increment an index modulo n (n >= 1).
  function automatic int unsigned wrapInc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/process_allocator_arbiter_if.sv
// Core-side bundle: per-core requests in, completion pulses and the crossbar
// grant out. master = the requesting cores, slave = the arbiter.
interface process_allocator_arbiter_if
  import process_allocator_arbiter_pkg::*;
#(
  parameter int unsigned addrBits    = 8,
  parameter int unsigned numCores    = 4,
  parameter int unsigned coreIdxBits = 2
) ();

  logic [numCores-1:0]          reqValid;
  logic [numCores-1:0]          reqIsCreate;
  logic [numCores*addrBits-1:0] reqWordsToCopy;
  logic [numCores*PC_BITS-1:0]  reqStartPc;
  logic [numCores*addrBits-1:0] reqPidToFree;

  logic [numCores-1:0]          respValid;
  logic [addrBits-1:0]          respPid;
  logic                         respError;
  logic                         grantValid;
  logic [coreIdxBits-1:0]       grantIndex;

  modport master (
    output reqValid, reqIsCreate, reqWordsToCopy, reqStartPc, reqPidToFree,
    input  respValid, respPid, respError, grantValid, grantIndex
  );

  modport slave (
    input  reqValid, reqIsCreate, reqWordsToCopy, reqStartPc, reqPidToFree,
    output respValid, respPid, respError, grantValid, grantIndex
  );

endinterface

// File: rtl/process_allocator_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first set request bit scanning upward
// from rrPtr with wrap-around.
module rr_priority_picker #(
  parameter int unsigned numCores    = 4,
  parameter int unsigned coreIdxBits = 2
) (
  input  logic [numCores-1:0]    reqValid,
  input  logic [coreIdxBits-1:0] rrPtr,
  output logic                   any_c,
  output logic [coreIdxBits-1:0] index_c
);

  always_comb begin
    logic        found;
    int unsigned cand;
    any_c   = |reqValid;
    index_c = '0;
    found   = 1'b0;
    cand    = 0;
    for (int unsigned k = 0; k < numCores; k++) begin
      cand = 32'(rrPtr) + k;
      if (cand >= numCores) cand = cand - numCores;
      if (!found && reqValid[coreIdxBits'(cand)]) begin
        index_c = coreIdxBits'(cand);
        found   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/process_allocator_arbiter.sv
// Round-robin arbiter sharing one ProcessAllocator among numCores cores;
// drives the enabled/finished handshake and returns PID or error to the winner.
module process_allocator_arbiter
  import process_allocator_arbiter_pkg::*;
#(
  parameter int unsigned addrBits      = 8,
  parameter int unsigned numCores      = 4,
  parameter int unsigned coreIdxBits   = 2,
  parameter int unsigned timeoutCycles = 1024
) (
  input  logic                clk,
  input  logic                reset,
  process_allocator_arbiter_if.slave core,
  output logic                allocEnabled,
  output logic                allocHasProcessCreate,
  output logic [addrBits-1:0] allocWordsToCopy,
  output logic [PC_BITS-1:0]  allocStartPc,
  output logic [addrBits-1:0] allocPidToFree,
  input  logic                allocFinished,
  input  logic [addrBits-1:0] allocNewPid
);

  localparam int unsigned cntBits = (timeoutCycles > 2) ? $clog2(timeoutCycles) : 1;
  localparam logic [cntBits-1:0] cntLast = cntBits'(timeoutCycles - 1);

  arbState_t              state;
  logic [coreIdxBits-1:0] rrPtr;
  logic [cntBits-1:0]     busyCnt;
  logic                   pickAny;
  logic [coreIdxBits-1:0] pickIdx;

  rr_priority_picker #(
    .numCores    (numCores),
    .coreIdxBits (coreIdxBits)
  ) uPicker (
    .reqValid (core.reqValid),
    .rrPtr    (rrPtr),
    .any_c    (pickAny),
    .index_c  (pickIdx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state                 <= IDLE;
      rrPtr                 <= '0;
      busyCnt               <= '0;
      core.respValid        <= '0;
      core.respPid          <= '0;
      core.respError        <= 1'b0;
      core.grantValid       <= 1'b0;
      core.grantIndex       <= '0;
      allocEnabled          <= 1'b0;
      allocHasProcessCreate <= 1'b0;
      allocWordsToCopy      <= '0;
      allocStartPc          <= '0;
      allocPidToFree        <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Latch the winner's operands; they stay stable for the whole BUSY phase.
          if (pickAny) begin
            core.grantIndex       <= pickIdx;
            core.grantValid       <= 1'b1;
            allocEnabled          <= 1'b1;
            allocHasProcessCreate <= core.reqIsCreate[pickIdx];
            allocWordsToCopy      <= core.reqWordsToCopy[pickIdx*addrBits +: addrBits];
            allocStartPc          <= core.reqStartPc[pickIdx*PC_BITS +: PC_BITS];
            allocPidToFree        <= core.reqPidToFree[pickIdx*addrBits +: addrBits];
            busyCnt               <= '0;
            state                 <= BUSY;
          end
        end

        BUSY: begin
          if (allocFinished) begin
            allocEnabled   <= 1'b0;
            core.respValid <= numCores'(1) << core.grantIndex;
            if (allocHasProcessCreate) begin
              core.respPid   <= allocNewPid;
              core.respError <= (allocNewPid == addrBits'(PID_NONE));
            end else begin
              core.respPid   <= allocPidToFree;
              core.respError <= 1'b0;
            end
            state <= RESP;
          end else if (busyCnt == cntLast) begin
            // Allocator never answered: abort and report an error.
            allocEnabled   <= 1'b0;
            core.respValid <= numCores'(1) << core.grantIndex;
            core.respPid   <= allocHasProcessCreate ? addrBits'(PID_NONE) : allocPidToFree;
            core.respError <= 1'b1;
            state          <= RESP;
          end else begin
            busyCnt <= busyCnt + 1'b1;
          end
        end

        RESP: begin
          core.respValid <= '0;
          core.respError <= 1'b0;
          rrPtr          <= coreIdxBits'(wrapInc(32'(core.grantIndex), numCores));
          state          <= DRAIN;
        end

        DRAIN: begin
          // Wait out a lingering finished so it cannot complete the next request.
          if (!allocFinished) begin
            core.grantValid <= 1'b0;
            state           <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
